// File: rtl/mmul_opa_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mmul_opa_sequencer_pkg
//   Shared constants and types for the operand-A sequencer of the Montgomery
//   multiplier: default word width, word count, derived operand width,
//   counter widths and the sequencer state encoding.
// ----------------------------------------------------------------------------
package mmul_opa_sequencer_pkg;

  localparam int DEF_WORD_W = 16;                       // bits per input word
  localparam int DEF_NWORDS = 16;                       // words per operand
  localparam int DEF_OPW    = DEF_WORD_W * DEF_NWORDS;  // operand width (256)

  localparam int DEF_WCNT_W = $clog2(DEF_NWORDS);       // word counter width
  localparam int DEF_BIDX_W = $clog2(DEF_OPW);          // bit index width

  // Fixed encodings: downstream debug tooling decodes these values.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : mmul_opa_sequencer_pkg

// File: rtl/mmul_opa_sequencer_if.sv
// ----------------------------------------------------------------------------
// mmul_opa_if
//   Operand word stream into the sequencer.
//
//   Handshake: a word transfers on a rising clock edge where in_valid and
//   in_ready are both 1. in_valid may be raised without waiting for
//   in_ready; once raised, in_word must stay stable until the transfer.
//   in_ready may change freely from cycle to cycle.
//
//   Signals
//     in_word   W bits   operand word, least-significant word first
//     in_valid  1        in_word holds a word
//     in_ready  1        sequencer takes in_word this cycle
//   Modports
//     master    upstream producer (drives in_word/in_valid)
//     slave     sequencer (drives in_ready)
// ----------------------------------------------------------------------------
interface mmul_opa_if #(
  parameter int W = 16
);

  logic [W-1:0] in_word;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output in_word,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_word,
    input  in_valid,
    output in_ready
  );

endinterface : mmul_opa_if

// File: rtl/mmul_opa_sequencer_step_cnt.sv
// ----------------------------------------------------------------------------
// mmul_step_cnt
//   Up-counter with synchronous clear, count enable and a terminal flag.
//   Clear has priority over enable.
//
//   Ports
//     clk    in   1   rising-edge clock
//     clr    in   1   synchronous clear to zero
//     en     in   1   increment by one
//     count  out  W   current count
//     term   out  1   count == TERM
// ----------------------------------------------------------------------------
module mmul_step_cnt #(
  parameter int W    = 4,
  parameter int TERM = 15
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         term
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign term = (count == TERM_V);

endmodule : mmul_step_cnt

// File: rtl/mmul_opa_sequencer.sv
// ----------------------------------------------------------------------------
// mmul_opa_sequencer
//   Control stage in front of the operand-A shift register of the Montgomery
//   multiplier. Loads operand A word by word (LSW first) through the
//   register's 16-bit load path, then steps the register one bit per core
//   acknowledge so the core sees A[i] on regout[0].
//
//   Ports
//     clk, rst      clock and synchronous active-high reset
//     start         one-cycle request for a new operand, honoured in IDLE
//     abort         synchronous abort back to IDLE, no done pulse
//     opa_stream    operand word stream (slave side)
//     reg_din       load data to operand register (= in_word)
//     reg_we        operand register write enable (combinational)
//     reg_sel       0 = word-wide load shift, 1 = one-bit shift
//     bit_valid     regout[0] holds A[bit_idx]
//     bit_ack       core consumed the current bit
//     bit_idx       index of the bit at regout[0]
//     bit_last      bit_valid and bit_idx is the operand's top bit
//     busy          sequencer is not IDLE
//     done          one-cycle pulse after the top bit is acknowledged
//     state_dbg     current FSM state
//     word_cnt_dbg  words accepted so far in the current load
//
//   State flow: IDLE -> LOAD -> SHIFT -> DONE -> IDLE; abort returns to IDLE
//   from anywhere. reg_we, reg_din and in_ready are combinational; all other
//   outputs are registered from the next state.
// ----------------------------------------------------------------------------
module mmul_opa_sequencer
  import mmul_opa_sequencer_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int NWORDS = DEF_NWORDS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  mmul_opa_if.slave                         opa_stream,
  output logic [WORD_W-1:0]                 reg_din,
  output logic                              reg_we,
  output logic                              reg_sel,
  output logic                              bit_valid,
  input  logic                              bit_ack,
  output logic [$clog2(WORD_W*NWORDS)-1:0]  bit_idx,
  output logic                              bit_last,
  output logic                              busy,
  output logic                              done,
  output state_t                            state_dbg,
  output logic [$clog2(NWORDS)-1:0]         word_cnt_dbg
);

  localparam int OPW    = WORD_W * NWORDS;
  localparam int WCNT_W = $clog2(NWORDS);
  localparam int BIDX_W = $clog2(OPW);

  // Index one below the top bit: an ack there makes the next bit the last.
  localparam logic [BIDX_W-1:0] IDX_PENULT = BIDX_W'(OPW - 2);

  state_t state;
  state_t state_next;

  logic load_hs;    // word accepted into the register this cycle
  logic shift_hs;   // bit consumed, register shifts by one this cycle

  logic [WCNT_W-1:0] word_cnt;
  logic              word_term;
  logic              word_clr;
  logic              bit_term;
  logic              bit_clr;

  logic busy_d;
  logic done_d;
  logic bit_valid_d;
  logic bit_last_d;
  logic reg_sel_d;

  // Abort and reset both block any transfer in the cycle they are seen.
  assign load_hs  = (state == ST_LOAD)  && opa_stream.in_valid && !abort && !rst;
  assign shift_hs = (state == ST_SHIFT) && bit_ack             && !abort && !rst;

  // Counters sit at zero outside their own state, so entering LOAD/SHIFT
  // always starts from 0 and a stray start cannot disturb them.
  assign word_clr = rst || abort || (state != ST_LOAD)  || (load_hs  && word_term);
  assign bit_clr  = rst || abort || (state != ST_SHIFT) || (shift_hs && bit_term);

  mmul_step_cnt #(
    .W    (WCNT_W),
    .TERM (NWORDS - 1)
  ) u_word_cnt (
    .clk   (clk),
    .clr   (word_clr),
    .en    (load_hs),
    .count (word_cnt),
    .term  (word_term)
  );

  mmul_step_cnt #(
    .W    (BIDX_W),
    .TERM (OPW - 1)
  ) u_bit_cnt (
    .clk   (clk),
    .clr   (bit_clr),
    .en    (shift_hs),
    .count (bit_idx),
    .term  (bit_term)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start)                 state_next = ST_LOAD;
        ST_LOAD:  if (load_hs && word_term)  state_next = ST_SHIFT;
        ST_SHIFT: if (shift_hs && bit_term)  state_next = ST_DONE;
        ST_DONE:                             state_next = ST_IDLE;
        default:                             state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode: combinational outputs plus next values of the
  // registered ones.
  always_comb begin
    opa_stream.in_ready = (state == ST_LOAD) && !abort && !rst;
    reg_we              = load_hs || shift_hs;
    reg_din             = opa_stream.in_word;

    busy_d      = (state_next != ST_IDLE);
    done_d      = (state_next == ST_DONE);
    bit_valid_d = (state_next == ST_SHIFT);
    reg_sel_d   = (state_next == ST_SHIFT);
    // On the LOAD->SHIFT step the index starts at 0, never the last bit.
    bit_last_d  = (state_next == ST_SHIFT) && (state == ST_SHIFT) &&
                  (shift_hs ? (bit_idx == IDX_PENULT) : bit_term);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_valid <= 1'b0;
      reg_sel   <= 1'b0;
      bit_last  <= 1'b0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      bit_valid <= bit_valid_d;
      reg_sel   <= reg_sel_d;
      bit_last  <= bit_last_d;
    end
  end

  assign state_dbg    = state;
  assign word_cnt_dbg = word_cnt;

endmodule : mmul_opa_sequencer

// File: tb/tb_mmul_opa_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mmul_opa_sequencer
//   Bench for mmul_opa_sequencer with a 256-bit operand register model and a
//   core model that acknowledges bits. Expected bit-stream entries are queued
//   when an operand is issued; a negedge monitor pops and compares them on
//   every bit handshake.
// ----------------------------------------------------------------------------
module tb_mmul_opa_sequencer;
  import mmul_opa_sequencer_pkg::*;

  localparam int PERIOD = 10;

  // Clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // DUT connections
  logic        start;
  logic        abort;
  logic [15:0] reg_din;
  logic        reg_we;
  logic        reg_sel;
  logic        bit_valid;
  logic        bit_ack;
  logic [7:0]  bit_idx;
  logic        bit_last;
  logic        busy;
  logic        done;
  state_t      state_dbg;
  logic [3:0]  word_cnt_dbg;

  mmul_opa_if #(.W(16)) opa_stream ();

  mmul_opa_sequencer #(
    .WORD_W (16),
    .NWORDS (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .opa_stream   (opa_stream.slave),
    .reg_din      (reg_din),
    .reg_we       (reg_we),
    .reg_sel      (reg_sel),
    .bit_valid    (bit_valid),
    .bit_ack      (bit_ack),
    .bit_idx      (bit_idx),
    .bit_last     (bit_last),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg),
    .word_cnt_dbg (word_cnt_dbg)
  );

  // Operand register model: word load shifts right by 16 with the new word
  // entering at the top; bit shift moves right by one. regout[0] = opreg[0].
  logic [255:0] opreg;
  always @(posedge clk) begin
    if (reg_we) begin
      if (reg_sel) opreg <= {1'b0, opreg[255:1]};
      else         opreg <= {reg_din, opreg[255:16]};
    end
  end

  // Scoreboard state
  logic [9:0] exp_q[$];      // {bit_idx, bit_last, bit}
  int n_cmp;
  int n_err;
  int load_wr;
  int shift_wr;
  int done_cnt;
  longint t_start;
  longint t_done;

  logic [15:0]  words [16];
  logic [255:0] a_bits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the bit stream and checks every register write.
  always @(negedge clk) begin
    logic [9:0] exp_item;
    if (!rst) begin
      if (bit_valid && bit_ack && !abort) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL bit_stream: got bit at idx %0d expected none", bit_idx);
        end else begin
          exp_item = exp_q.pop_front();
          check("bit_stream", 32'({bit_idx, bit_last, opreg[0]}), 32'(exp_item));
        end
      end
      if (reg_we) begin
        if (reg_sel) begin
          shift_wr++;
          check("we_shift_needs_ack", 32'(bit_ack), 32'd1);
        end else begin
          load_wr++;
          check("we_load_needs_valid", 32'(opa_stream.in_valid), 32'd1);
        end
        check("we_blocked_by_abort", 32'(abort), 32'd0);
      end
      if (done) begin
        done_cnt++;
        t_done = $time;
      end
    end
  end

  // Driver: one operand from start to completion (or abort).
  //   vmode          0 = in_valid always 1, 1 = in_valid toggles 1/0
  //   period         bit_ack asserted every period-th cycle
  //   abort_at       abort when this many bits are consumed (-1 = never)
  //   start_at_word  pulse start again after this many words (-1 = never)
  //   stray_ack      hold bit_ack high during the load phase
  //   check_latency  check the start-to-done time for continuous flow
  task automatic run_operand(input int vmode, input int period, input int abort_at,
                             input int start_at_word, input bit stray_ack,
                             input bit check_latency);
    int  nbits;
    int  w;
    int  b;
    int  guard;
    bit  hs;
    bit  restarted;
    bit  aborted;

    load_wr  = 0;
    shift_wr = 0;
    done_cnt = 0;
    t_done   = 0;
    nbits    = (abort_at >= 0) ? abort_at : 256;
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back({8'(i), (i == 255) ? 1'b1 : 1'b0, a_bits[i]});
    end

    start = 1'b1;
    @(posedge clk);
    t_start = $time;
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);

    // Load phase
    w = 0;
    guard = 0;
    restarted = 1'b0;
    while (w < 16 && guard < 200) begin
      opa_stream.in_word  = words[w];
      opa_stream.in_valid = (vmode == 0) || (guard % 2 == 0);
      bit_ack = stray_ack;
      if (start_at_word == w && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      hs = opa_stream.in_valid && opa_stream.in_ready;
      tick();
      if (hs) w++;
      guard++;
      if (start_at_word >= 0 && w < 16) check("word_cnt_track", 32'(word_cnt_dbg), 32'(w));
    end
    start = 1'b0;
    opa_stream.in_valid = 1'b0;
    bit_ack = 1'b0;
    check("load_words_taken", 32'(w), 32'd16);
    check("bit_valid_after_load", 32'(bit_valid), 32'd1);

    // Shift phase
    b = 0;
    guard = 0;
    aborted = 1'b0;
    while (b < 256 && guard < 2000 && !aborted) begin
      if (b == abort_at) begin
        abort   = 1'b1;
        bit_ack = 1'b1;
        tick();
        abort   = 1'b0;
        bit_ack = 1'b0;
        aborted = 1'b1;
      end else begin
        bit_ack = ((guard % period) == (period - 1));
        hs = bit_ack && bit_valid;
        tick();
        if (hs) b++;
        guard++;
      end
    end
    bit_ack = 1'b0;
    check("bits_consumed", 32'(b), 32'(nbits));
    if (abort_at >= 0) begin
      check("abort_state_idle", 32'(state_dbg), 32'(ST_IDLE));
      check("abort_bit_valid", 32'(bit_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
    end

    repeat (3) tick();
    check("done_pulses", 32'(done_cnt), (abort_at >= 0) ? 32'd0 : 32'd1);
    check("load_writes", 32'(load_wr), 32'd16);
    check("shift_writes", 32'(shift_wr), 32'(nbits));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("idle_after_run", 32'(busy), 32'd0);
    // Start cycle + 16 load + 256 shift + done cycle = 274 cycles; done is
    // seen at the negedge 272 edges after the start edge.
    if (check_latency) check("start_to_done", 32'(t_done - t_start), 32'(272*PERIOD + PERIOD/2));
    exp_q.delete();
  endtask

  // Watchdog
  initial begin
    #(600000);
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    n_cmp = 0;
    n_err = 0;
    load_wr = 0;
    shift_wr = 0;
    done_cnt = 0;
    opreg = '0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bit_ack = 1'b0;
    opa_stream.in_word  = 16'hA5A5;
    opa_stream.in_valid = 1'b0;

    // Operand A: words 1..16, LSW first -> A[0]=1, A[16]=0, A[17]=1
    for (int i = 0; i < 16; i++) begin
      words[i] = 16'(i + 1);
      a_bits[i*16 +: 16] = 16'(i + 1);
    end

    // T1 reset
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(opa_stream.in_ready), 32'd0);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_bit_idx", 32'(bit_idx), 32'd0);
    check("rst_bit_last", 32'(bit_last), 32'd0);
    check("rst_reg_din", 32'(reg_din), 32'h0000_A5A5);
    rst = 1'b0;
    tick();
    check("idle_state", 32'(state_dbg), 32'(ST_IDLE));

    // T2 full operand, continuous flow
    run_operand(0, 1, -1, -1, 1'b0, 1'b1);

    // T3 backpressure: valid toggles, ack every third cycle
    run_operand(1, 3, -1, -1, 1'b0, 1'b0);

    // T4 abort at bit 100, then a clean reload
    run_operand(0, 1, 100, -1, 1'b0, 1'b0);
    run_operand(0, 1, -1, -1, 1'b0, 1'b1);

    // T5a start during LOAD is ignored
    run_operand(0, 2, -1, 5, 1'b0, 1'b0);

    // T5b start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_ready", 32'(opa_stream.in_ready), 32'd0);

    // T5c reset during LOAD after 7 words
    start = 1'b1;
    tick();
    start = 1'b0;
    opa_stream.in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      opa_stream.in_word = words[i];
      tick();
    end
    check("pre_rst_word_cnt", 32'(word_cnt_dbg), 32'd7);
    rst = 1'b1;
    opa_stream.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst_load_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_load_busy", 32'(busy), 32'd0);
    check("rst_load_ready", 32'(opa_stream.in_ready), 32'd0);
    check("rst_load_word_cnt", 32'(word_cnt_dbg), 32'd0);

    // T6 stray in_valid in IDLE, stray bit_ack in LOAD
    load_wr = 0;
    opa_stream.in_valid = 1'b1;
    repeat (3) tick();
    opa_stream.in_valid = 1'b0;
    check("stray_valid_writes", 32'(load_wr), 32'd0);
    check("stray_valid_state", 32'(state_dbg), 32'(ST_IDLE));
    check("stray_valid_word_cnt", 32'(word_cnt_dbg), 32'd0);
    run_operand(1, 1, -1, -1, 1'b1, 1'b0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mmul_opa_sequencer
